// File: rtl/scinstloader.sv
// Boot-time instruction-memory loader: header byte N, then N big-endian words written to IM.
// Optional trailing XOR checksum byte when SCINSTLOADER_CSUM_EN is defined.
module scinstloader #(
  parameter int unsigned ADDR_W = 5,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_din,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_clrn
);

  typedef enum logic [2:0] {StIdle, StHdr, StData, StWrite, StCsum, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         word_q, word_d;
  logic                im_we_q, im_we_d;
  logic [31:0]         im_addr_q, im_addr_d;
  logic [31:0]         im_din_q, im_din_d;
  logic                done_q, done_d;
  logic                cpu_clrn_q, cpu_clrn_d;
`ifdef SCINSTLOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      last_q     <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE;
      im_din_q   <= '0;
      done_q     <= 1'b0;
      cpu_clrn_q <= 1'b0;
`ifdef SCINSTLOADER_CSUM_EN
      csum_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_din_q   <= im_din_d;
      done_q     <= done_d;
      cpu_clrn_q <= cpu_clrn_d;
`ifdef SCINSTLOADER_CSUM_EN
      csum_q     <= csum_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    im_addr_d  = im_addr_q;
    im_din_d   = im_din_q;
    done_d     = done_q;
    cpu_clrn_d = cpu_clrn_q;
    rx_ready   = 1'b0;
`ifdef SCINSTLOADER_CSUM_EN
    csum_d     = csum_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          done_d     = 1'b0;
          cpu_clrn_d = 1'b0;
          idx_d      = '0;
          bcnt_d     = '0;
`ifdef SCINSTLOADER_CSUM_EN
          err_d      = 1'b0;
`endif
          state_d    = StHdr;
        end
      end
      StHdr: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          // N=0 (after truncation) wraps to all-ones: the full depth.
          last_d  = ADDR_W'(rx_data) - ADDR_W'(1);
`ifdef SCINSTLOADER_CSUM_EN
          csum_d  = rx_data;
`endif
          state_d = StData;
        end
      end
      StData: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          word_d = {word_q[15:0], rx_data};
          bcnt_d = bcnt_q + 2'd1;
`ifdef SCINSTLOADER_CSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            im_din_d  = {word_q, rx_data};
            im_addr_d = BASE + 32'({idx_q, 2'b00});
            state_d   = StWrite;
          end
        end
      end
      StWrite: begin
        if (idx_q == last_q) begin
`ifdef SCINSTLOADER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = StData;
        end
      end
      StCsum: begin
`ifdef SCINSTLOADER_CSUM_EN
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = StDone;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        done_d     = 1'b1;
        cpu_clrn_d = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Strobe registered so it lines up with the WRITE state cycle.
    im_we_d = (state_d == StWrite);
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_din   = im_din_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign cpu_clrn = cpu_clrn_q;
`ifdef SCINSTLOADER_CSUM_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_scinstloader.sv
// Directed bench for scinstloader: table of load cases plus reset-abort and checksum sequences.
// Honours SCINSTLOADER_CSUM_EN to match the DUT build.
module tb_scinstloader;

`ifdef SCINSTLOADER_CSUM_EN
  localparam int CSX = 1;
`else
  localparam int CSX = 0;
`endif

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_din;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_clrn;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int nacc     = 0;
  int viol     = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  scinstloader dut (
    .clk      (clk),
    .clrn     (clrn),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_din   (im_din),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_clrn (cpu_clrn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid && rx_ready) nacc <= nacc + 1;
  end

  always @(negedge clk) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_din);
    end
    if (busy && cpu_clrn) viol <= viol + 1;
  end

  typedef struct {
    logic [7:0]  hdr;
    int          nw;
    bit          gap;
    int          exp_lat;
    logic [31:0] exp_last;
    int          restart;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dbyte(input int j);
    case (j)
      0: return 8'h3c;
      1: return 8'h01;
      2: return 8'h00;
      3: return 8'h00;
      4: return 8'h34;
      5: return 8'h24;
      6: return 8'h00;
      7: return 8'h50;
      default: return 8'(j * 37 + 11);
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int i);
    return {dbyte(4*i), dbyte(4*i+1), dbyte(4*i+2), dbyte(4*i+3)};
  endfunction

  // Call at a negedge; returns at the negedge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready wait bound", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rx_ready"}, rx_ready, 1'b0);
    check({tag, " im_we"},    im_we,    1'b0);
    check({tag, " im_addr"},  im_addr,  32'h0);
    check({tag, " im_din"},   im_din,   32'h0);
    check({tag, " busy"},     busy,     1'b0);
    check({tag, " done"},     done,     1'b0);
    check({tag, " err"},      err,      1'b0);
    check({tag, " cpu_clrn"}, cpu_clrn, 1'b0);
  endtask

  task automatic run_load(input logic [7:0] hdr, input int nw, input int restart,
                          input bit gap, input bit bad, output int lat);
    logic [7:0] cs;
    int c0;
    int k;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("busy after start", busy, 1'b1);
    check("done cleared by start", done, 1'b0);
    check("cpu_clrn low after start", cpu_clrn, 1'b0);
    cs = hdr;
    send_byte(hdr);
    if (gap) @(negedge clk);
    for (int j = 0; j < nw * 4; j++) begin
      if (j == restart) start = 1'b1;
      send_byte(dbyte(j));
      start = 1'b0;
      cs = cs ^ dbyte(j);
      if (gap) @(negedge clk);
    end
`ifdef SCINSTLOADER_CSUM_EN
    send_byte(bad ? 8'h00 : cs);
`else
    if (bad) cs = 8'h00;
`endif
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("load finished", busy, 1'b0);
    lat = cyc - c0 - 1;
  endtask

  task automatic check_load(input int nw, input logic [31:0] exp_last, input int wb,
                            input int ab, input int vb, input bit good);
    check("write count", wa.size() - wb, nw);
    for (int i = 0; i < nw; i++) begin
      if (wb + i < wa.size()) begin
        check("write addr", wa[wb+i], 32'(4 * i));
        check("write data", wd[wb+i], model_word(i));
      end
    end
    if (wa.size() > wb) check("last write addr", wa[wa.size()-1], exp_last);
    check("bytes accepted", nacc - ab, 1 + 4 * nw + CSX);
    check("cpu_clrn low while busy", viol - vb, 0);
    check("done", done, good);
    check("cpu_clrn", cpu_clrn, good);
    check("err", err, !good);
  endtask

  initial begin
    int lat;
    int wb;
    int ab;
    int vb;
    clrn     = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1 clrn = 1'b0;
    #2 check_reset("reset");
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    vt[0] = '{8'h02,  2, 1'b0,  12, 32'h0000_0004, -1};
    vt[1] = '{8'h02,  2, 1'b1,  -1, 32'h0000_0004, -1};
    vt[2] = '{8'h00, 32, 1'b0, 162, 32'h0000_007c, -1};
    vt[3] = '{8'h21,  1, 1'b0,   7, 32'h0000_0000, -1};
    vt[4] = '{8'h20, 32, 1'b1,  -1, 32'h0000_007c, -1};
    vt[5] = '{8'h02,  2, 1'b0,  12, 32'h0000_0004,  3};

    for (int i = 0; i < 6; i++) begin
      wb = wa.size();
      ab = nacc;
      vb = viol;
      run_load(vt[i].hdr, vt[i].nw, vt[i].restart, vt[i].gap, 1'b0, lat);
      check_load(vt[i].nw, vt[i].exp_last, wb, ab, vb, 1'b1);
      if (vt[i].exp_lat >= 0) check("load latency", lat, vt[i].exp_lat + CSX);
      if (vt[i].hdr == 8'h02 && wa.size() >= wb + 2) begin
        check("word0 value", wd[wb], 32'h3c01_0000);
        check("word1 value", wd[wb+1], 32'h3424_0050);
      end
    end

    // Reset after the 6th byte aborts; the first word has already been written.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wb = wa.size();
    send_byte(8'h02);
    for (int j = 0; j < 5; j++) send_byte(dbyte(j));
    clrn = 1'b0;
    #1 check_reset("abort");
    check("writes before abort", wa.size() - wb, 1);
    @(negedge clk);
    clrn = 1'b1;
    wb = wa.size();
    ab = nacc;
    vb = viol;
    run_load(8'h02, 2, -1, 1'b0, 1'b0, lat);
    check_load(2, 32'h0000_0004, wb, ab, vb, 1'b1);
    check("latency after abort", lat, 12 + CSX);

`ifdef SCINSTLOADER_CSUM_EN
    wb = wa.size();
    ab = nacc;
    vb = viol;
    run_load(8'h02, 2, -1, 1'b0, 1'b1, lat);
    check_load(2, 32'h0000_0004, wb, ab, vb, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
